// File: rtl/bus_decoder.sv
// bus_decoder: memory-map decoder and wait-state generator between the CPU
// bus bridge and the on-chip regions. Each strobe is matched against
// NUM_REGIONS base/mask windows (lowest index wins). A per-region wait count
// stretches the transaction while READY is held low. Unmapped accesses
// return OPEN_BUS on reads, drop writes and bump a saturating error count.
module bus_decoder #(
    parameter int                        NUM_REGIONS = 4,
    parameter logic [NUM_REGIONS*20-1:0] REGION_BASE = {(NUM_REGIONS*20){1'b0}},
    parameter logic [NUM_REGIONS*20-1:0] REGION_MASK = {(NUM_REGIONS*20){1'b0}},
    parameter logic [NUM_REGIONS*4-1:0]  REGION_WAIT = {(NUM_REGIONS*4){1'b0}},
    parameter logic [7:0]                OPEN_BUS    = 8'hFF
) (
    input  logic                     iClk,
    input  logic                     iReset,
    input  logic [19:0]              iAddr,
    input  logic [7:0]               iData,
    input  logic                     iMemRd,
    input  logic                     iMemWr,
    input  logic [NUM_REGIONS*8-1:0] iRdData,
    output logic [NUM_REGIONS-1:0]   oSel,
    output logic [19:0]              oAddr,
    output logic [7:0]               oData,
    output logic                     oRd,
    output logic                     oWr,
    output logic [7:0]               oCpuData,
    output logic                     oReady,
    output logic                     oUnmapped,
    output logic [7:0]               oErrCount,
    output logic                     oOverrun
);

    localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_WAIT    = 2'd2,
        ST_CAPTURE = 2'd3
    } state_t;

    state_t                 state_r, state_nxt_s;
    logic [NUM_REGIONS-1:0] sel_r, sel_nxt_s;
    logic [19:0]            addr_r, addr_nxt_s;
    logic [7:0]             data_r, data_nxt_s;
    logic                   rd_r, rd_nxt_s;
    logic                   wr_r, wr_nxt_s;
    logic [7:0]             cpu_data_r, cpu_data_nxt_s;
    logic                   ready_r, ready_nxt_s;
    logic                   unmapped_r, unmapped_nxt_s;
    logic [7:0]             err_count_r, err_count_nxt_s;
    logic                   overrun_r, overrun_nxt_s;
    logic                   is_wr_r, is_wr_nxt_s;
    logic                   hit_r, hit_nxt_s;
    logic [IDX_W-1:0]       idx_r, idx_nxt_s;
    logic [3:0]             cnt_r, cnt_nxt_s;

    logic                   strobe_s;
    logic                   hit_any_s;
    logic [IDX_W-1:0]       hit_idx_s;
    logic [3:0]             hit_wait_s;
    logic [NUM_REGIONS-1:0] sel_onehot_s;
    logic [7:0]             rd_mux_s;

    assign strobe_s = iMemRd | iMemWr;

    // Window match with lowest-index priority: scan downwards so the lowest hit is kept last.
    always_comb begin
        hit_any_s  = 1'b0;
        hit_idx_s  = {IDX_W{1'b0}};
        hit_wait_s = 4'd0;
        for (int k = NUM_REGIONS - 1; k >= 0; k--) begin
            if ((iAddr & REGION_MASK[20*k +: 20]) == (REGION_BASE[20*k +: 20] & REGION_MASK[20*k +: 20])) begin
                hit_any_s  = 1'b1;
                hit_idx_s  = IDX_W'(k);
                hit_wait_s = REGION_WAIT[4*k +: 4];
            end else begin
                hit_any_s  = hit_any_s;
                hit_idx_s  = hit_idx_s;
                hit_wait_s = hit_wait_s;
            end
        end
    end

    // One-hot select for the winning window, all zero when nothing hits.
    always_comb begin
        sel_onehot_s = {NUM_REGIONS{1'b0}};
        for (int k = 0; k < NUM_REGIONS; k++) begin
            sel_onehot_s[k] = hit_any_s && (hit_idx_s == IDX_W'(k));
        end
    end

    // Read-data return mux over the latched region; open-bus when unmapped.
    always_comb begin
        rd_mux_s = OPEN_BUS;
        for (int k = 0; k < NUM_REGIONS; k++) begin
            if (hit_r && (idx_r == IDX_W'(k))) begin
                rd_mux_s = iRdData[8*k +: 8];
            end else begin
                rd_mux_s = rd_mux_s;
            end
        end
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_nxt_s     = state_r;
        sel_nxt_s       = sel_r;
        addr_nxt_s      = addr_r;
        data_nxt_s      = data_r;
        rd_nxt_s        = 1'b0;
        wr_nxt_s        = 1'b0;
        cpu_data_nxt_s  = cpu_data_r;
        ready_nxt_s     = ready_r;
        unmapped_nxt_s  = 1'b0;
        err_count_nxt_s = err_count_r;
        overrun_nxt_s   = overrun_r;
        is_wr_nxt_s     = is_wr_r;
        hit_nxt_s       = hit_r;
        idx_nxt_s       = idx_r;
        cnt_nxt_s       = cnt_r;

        case (state_r)
            ST_IDLE: begin
                if (strobe_s) begin
                    // Write wins when both strobes arrive together.
                    state_nxt_s    = ST_ACCESS;
                    addr_nxt_s     = iAddr;
                    data_nxt_s     = iData;
                    is_wr_nxt_s    = iMemWr;
                    hit_nxt_s      = hit_any_s;
                    idx_nxt_s      = hit_idx_s;
                    cnt_nxt_s      = hit_any_s ? hit_wait_s : 4'd0;
                    sel_nxt_s      = sel_onehot_s;
                    rd_nxt_s       = hit_any_s & ~iMemWr;
                    wr_nxt_s       = hit_any_s & iMemWr;
                    ready_nxt_s    = 1'b0;
                    unmapped_nxt_s = ~hit_any_s;
                    if (!hit_any_s && (err_count_r != 8'hFF)) begin
                        err_count_nxt_s = err_count_r + 8'd1;
                    end else begin
                        err_count_nxt_s = err_count_r;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                overrun_nxt_s = overrun_r | strobe_s;
                if (cnt_r != 4'd0) begin
                    state_nxt_s = ST_WAIT;
                end else if (is_wr_r) begin
                    state_nxt_s = ST_IDLE;
                    ready_nxt_s = 1'b1;
                    sel_nxt_s   = {NUM_REGIONS{1'b0}};
                end else begin
                    state_nxt_s = ST_CAPTURE;
                end
            end
            ST_WAIT: begin
                // Counter holds the number of wait cycles still to run, including this one.
                overrun_nxt_s = overrun_r | strobe_s;
                cnt_nxt_s     = cnt_r - 4'd1;
                if (cnt_r <= 4'd1) begin
                    if (is_wr_r) begin
                        state_nxt_s = ST_IDLE;
                        ready_nxt_s = 1'b1;
                        sel_nxt_s   = {NUM_REGIONS{1'b0}};
                    end else begin
                        state_nxt_s = ST_CAPTURE;
                    end
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_CAPTURE: begin
                // Region data sampled one full cycle after the last wait cycle.
                overrun_nxt_s  = overrun_r | strobe_s;
                cpu_data_nxt_s = rd_mux_s;
                ready_nxt_s    = 1'b1;
                sel_nxt_s      = {NUM_REGIONS{1'b0}};
                state_nxt_s    = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                ready_nxt_s = 1'b1;
                sel_nxt_s   = {NUM_REGIONS{1'b0}};
            end
        endcase
    end

    // State and output registers with asynchronous reset back to idle.
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            state_r     <= ST_IDLE;
            sel_r       <= {NUM_REGIONS{1'b0}};
            addr_r      <= 20'h00000;
            data_r      <= 8'h00;
            rd_r        <= 1'b0;
            wr_r        <= 1'b0;
            cpu_data_r  <= 8'h00;
            ready_r     <= 1'b1;
            unmapped_r  <= 1'b0;
            err_count_r <= 8'h00;
            overrun_r   <= 1'b0;
            is_wr_r     <= 1'b0;
            hit_r       <= 1'b0;
            idx_r       <= {IDX_W{1'b0}};
            cnt_r       <= 4'd0;
        end else begin
            state_r     <= state_nxt_s;
            sel_r       <= sel_nxt_s;
            addr_r      <= addr_nxt_s;
            data_r      <= data_nxt_s;
            rd_r        <= rd_nxt_s;
            wr_r        <= wr_nxt_s;
            cpu_data_r  <= cpu_data_nxt_s;
            ready_r     <= ready_nxt_s;
            unmapped_r  <= unmapped_nxt_s;
            err_count_r <= err_count_nxt_s;
            overrun_r   <= overrun_nxt_s;
            is_wr_r     <= is_wr_nxt_s;
            hit_r       <= hit_nxt_s;
            idx_r       <= idx_nxt_s;
            cnt_r       <= cnt_nxt_s;
        end
    end

    assign oSel      = sel_r;
    assign oAddr     = addr_r;
    assign oData     = data_r;
    assign oRd       = rd_r;
    assign oWr       = wr_r;
    assign oCpuData  = cpu_data_r;
    assign oReady    = ready_r;
    assign oUnmapped = unmapped_r;
    assign oErrCount = err_count_r;
    assign oOverrun  = overrun_r;

endmodule

// File: tb/tb_bus_decoder.sv
// Testbench for bus_decoder: directed test-plan scenarios plus randomized
// accesses checked against a behavioural memory-map/latency model.
module tb_bus_decoder;

    localparam int NR = 4;

    logic            iClk = 1'b0;
    logic            iReset;
    logic [19:0]     iAddr;
    logic [7:0]      iData;
    logic            iMemRd;
    logic            iMemWr;
    logic [NR*8-1:0] iRdData;
    logic [NR-1:0]   oSel;
    logic [19:0]     oAddr;
    logic [7:0]      oData;
    logic            oRd;
    logic            oWr;
    logic [7:0]      oCpuData;
    logic            oReady;
    logic            oUnmapped;
    logic [7:0]      oErrCount;
    logic            oOverrun;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state
    logic [19:0] base_m [NR];
    logic [19:0] mask_m [NR];
    int          wait_m [NR];
    logic [7:0]  err_m;
    logic [7:0]  cpu_m;
    logic        ov_m;
    logic [31:0] rd_vec;

    bus_decoder #(
        .NUM_REGIONS (NR),
        .REGION_BASE ({20'hF0000, 20'hB0000, 20'hFE000, 20'h00000}),
        .REGION_MASK ({20'hF0000, 20'hF0000, 20'hFF000, 20'h80000}),
        .REGION_WAIT ({4'd5, 4'd3, 4'd1, 4'd0}),
        .OPEN_BUS    (8'hFF)
    ) dut (
        .iClk      (iClk),
        .iReset    (iReset),
        .iAddr     (iAddr),
        .iData     (iData),
        .iMemRd    (iMemRd),
        .iMemWr    (iMemWr),
        .iRdData   (iRdData),
        .oSel      (oSel),
        .oAddr     (oAddr),
        .oData     (oData),
        .oRd       (oRd),
        .oWr       (oWr),
        .oCpuData  (oCpuData),
        .oReady    (oReady),
        .oUnmapped (oUnmapped),
        .oErrCount (oErrCount),
        .oOverrun  (oOverrun)
    );

    // 10 MHz clock
    always #50 iClk = ~iClk;

    // First window whose masked base equals the masked address, -1 if none.
    function automatic int model_region(input logic [19:0] a);
        for (int k = 0; k < NR; k++) begin
            if ((a & mask_m[k]) == (base_m[k] & mask_m[k])) return k;
        end
        return -1;
    endfunction

    // One access started in the current (idle) cycle; checks every cycle until READY returns.
    // inject_at > 0 pulses iMemRd during that cycle of the transaction.
    task automatic run_access(input logic [19:0] addr, input logic [7:0] data,
                              input logic wr, input logic both, input int inject_at);
        int         idx;
        int         w;
        int         low_cycles;
        logic       mapped;
        logic [3:0] exp_sel;
        logic [7:0] exp_rd;
        logic       e_rd, e_wr, e_un;
        idx     = model_region(addr);
        mapped  = (idx >= 0);
        exp_sel = 4'b0000;
        exp_rd  = 8'hFF;
        w       = 0;
        if (mapped) begin
            w       = wait_m[idx];
            exp_sel = 4'(1 << idx);
            exp_rd  = rd_vec[8*idx +: 8];
        end
        low_cycles = wr ? (1 + w) : (2 + w);
        if (!mapped) err_m = (err_m == 8'd255) ? 8'd255 : err_m + 8'd1;
        if (inject_at > 0) ov_m = 1'b1;

        iRdData = rd_vec;
        iAddr   = addr;
        iData   = data;
        iMemWr  = wr;
        iMemRd  = !wr || both;
        for (int n = 1; n <= low_cycles + 1; n++) begin
            @(negedge iClk);
            if (n == 1) begin
                iMemRd = 1'b0;
                iMemWr = 1'b0;
                iAddr  = 20'($urandom);
                iData  = 8'($urandom);
            end
            if (n == inject_at) iMemRd = 1'b1;
            if (n == inject_at + 1) iMemRd = 1'b0;

            if (n <= low_cycles) begin
                tests_run++;
                if (oReady !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL ready_low cyc%0d addr=%h: got %b expected 0", n, addr, oReady);
                end
                tests_run++;
                if (oSel !== exp_sel) begin
                    tests_failed++;
                    $display("FAIL sel cyc%0d addr=%h: got %b expected %b", n, addr, oSel, exp_sel);
                end
                tests_run++;
                if (oAddr !== addr || oData !== data) begin
                    tests_failed++;
                    $display("FAIL latch cyc%0d: got %h/%h expected %h/%h", n, oAddr, oData, addr, data);
                end
            end else begin
                tests_run++;
                if (oReady !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL ready_back cyc%0d addr=%h: got %b expected 1", n, addr, oReady);
                end
                tests_run++;
                if (oSel !== 4'b0000) begin
                    tests_failed++;
                    $display("FAIL sel_release addr=%h: got %b expected 0000", addr, oSel);
                end
            end
            e_rd = (n == 1) && !wr && mapped;
            e_wr = (n == 1) && wr && mapped;
            e_un = (n == 1) && !mapped;
            tests_run++;
            if (oRd !== e_rd || oWr !== e_wr || oUnmapped !== e_un) begin
                tests_failed++;
                $display("FAIL strobes cyc%0d addr=%h: got rd%b wr%b un%b expected rd%b wr%b un%b",
                         n, addr, oRd, oWr, oUnmapped, e_rd, e_wr, e_un);
            end
            if (n == 1) begin
                tests_run++;
                if (oErrCount !== err_m) begin
                    tests_failed++;
                    $display("FAIL err_count addr=%h: got %0d expected %0d", addr, oErrCount, err_m);
                end
            end
        end
        if (!wr) cpu_m = exp_rd;
        tests_run++;
        if (oCpuData !== cpu_m) begin
            tests_failed++;
            $display("FAIL cpu_data addr=%h wr=%b: got %h expected %h", addr, wr, oCpuData, cpu_m);
        end
        tests_run++;
        if (oOverrun !== ov_m) begin
            tests_failed++;
            $display("FAIL overrun addr=%h: got %b expected %b", addr, oOverrun, ov_m);
        end
    endtask

    task automatic test_reset();
        iReset  = 1'b1;
        iAddr   = 20'h00000;
        iData   = 8'h00;
        iMemRd  = 1'b0;
        iMemWr  = 1'b0;
        iRdData = '0;
        err_m   = 8'd0;
        cpu_m   = 8'd0;
        ov_m    = 1'b0;
        repeat (3) @(negedge iClk);
        tests_run++;
        if (oSel !== 4'b0000 || oRd !== 1'b0 || oWr !== 1'b0 || oReady !== 1'b1 ||
            oCpuData !== 8'h00 || oAddr !== 20'h00000 || oData !== 8'h00 ||
            oUnmapped !== 1'b0 || oErrCount !== 8'h00 || oOverrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_values: got sel=%b rd=%b wr=%b rdy=%b cpu=%h a=%h d=%h un=%b err=%h ov=%b expected idle values",
                     oSel, oRd, oWr, oReady, oCpuData, oAddr, oData, oUnmapped, oErrCount, oOverrun);
        end
        iReset = 1'b0;
        @(negedge iClk);
    endtask

    task automatic test_read_region0();
        rd_vec       = $urandom;
        rd_vec[7:0]  = 8'h5A;
        run_access(20'h01234, 8'h00, 1'b0, 1'b0, 0);
        tests_run++;
        if (oCpuData !== 8'h5A) begin
            tests_failed++;
            $display("FAIL read_region0: got %h expected 5a", oCpuData);
        end
    endtask

    task automatic test_write_wait();
        rd_vec = $urandom;
        run_access(20'hB0010, 8'h41, 1'b1, 1'b0, 0);
    endtask

    task automatic test_both_strobes();
        rd_vec = $urandom;
        run_access(20'h00042, 8'h99, 1'b1, 1'b1, 0);
    endtask

    task automatic test_unmapped();
        rd_vec = $urandom;
        run_access(20'hC0000, 8'h00, 1'b0, 1'b0, 0);
        tests_run++;
        if (oCpuData !== 8'hFF || oErrCount !== 8'd1) begin
            tests_failed++;
            $display("FAIL unmapped_read: got data %h count %0d expected ff count 1", oCpuData, oErrCount);
        end
    endtask

    task automatic test_overlap();
        rd_vec = $urandom;
        run_access(20'hFE000, 8'h00, 1'b0, 1'b0, 0);
        tests_run++;
        if (oCpuData !== rd_vec[15:8]) begin
            tests_failed++;
            $display("FAIL overlap_data: got %h expected %h", oCpuData, rd_vec[15:8]);
        end
    endtask

    task automatic test_overrun();
        rd_vec = $urandom;
        run_access(20'hF1234, 8'h00, 1'b0, 1'b0, 3);
        // the ignored strobe must not have started anything
        for (int n = 0; n < 4; n++) begin
            @(negedge iClk);
            tests_run++;
            if (oRd !== 1'b0 || oWr !== 1'b0 || oReady !== 1'b1 || oOverrun !== 1'b1) begin
                tests_failed++;
                $display("FAIL overrun_idle: got rd%b wr%b rdy%b ov%b expected rd0 wr0 rdy1 ov1",
                         oRd, oWr, oReady, oOverrun);
            end
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 300; i++) begin
            rd_vec = $urandom;
            run_access({4'hC, 16'($urandom)}, 8'($urandom), 1'($urandom), 1'b0, 0);
        end
        tests_run++;
        if (oErrCount !== 8'd255) begin
            tests_failed++;
            $display("FAIL err_saturate: got %0d expected 255", oErrCount);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            logic wr;
            rd_vec = $urandom;
            wr     = 1'($urandom);
            run_access(20'($urandom), 8'($urandom), wr, wr & 1'($urandom), 0);
        end
    endtask

    task automatic test_reset_mid();
        iAddr  = 20'hF0042;
        iData  = 8'h77;
        iMemWr = 1'b1;
        @(negedge iClk);
        iMemWr = 1'b0;
        repeat (3) @(negedge iClk);
        #10 iReset = 1'b1;
        #1;
        err_m = 8'd0;
        cpu_m = 8'd0;
        ov_m  = 1'b0;
        tests_run++;
        if (oReady !== 1'b1 || oSel !== 4'b0000 || oWr !== 1'b0 || oRd !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid: got rdy%b sel%b wr%b rd%b expected rdy1 sel0000 wr0 rd0",
                     oReady, oSel, oWr, oRd);
        end
        @(negedge iClk);
        iReset = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(negedge iClk);
            tests_run++;
            if (oRd !== 1'b0 || oWr !== 1'b0 || oReady !== 1'b1 || oSel !== 4'b0000) begin
                tests_failed++;
                $display("FAIL post_reset_quiet cyc%0d: got rd%b wr%b rdy%b sel%b expected 0 0 1 0000",
                         n, oRd, oWr, oReady, oSel);
            end
        end
        tests_run++;
        if (oErrCount !== 8'd0 || oOverrun !== 1'b0 || oCpuData !== 8'h00) begin
            tests_failed++;
            $display("FAIL post_reset_regs: got err%0d ov%b cpu%h expected 0 0 00", oErrCount, oOverrun, oCpuData);
        end
        // a fresh strobe works again
        rd_vec = $urandom;
        run_access(20'h7ABCD, 8'h00, 1'b0, 1'b0, 0);
    endtask

    initial begin
        base_m = '{20'h00000, 20'hFE000, 20'hB0000, 20'hF0000};
        mask_m = '{20'h80000, 20'hFF000, 20'hF0000, 20'hF0000};
        wait_m = '{0, 1, 3, 5};
        test_reset();
        test_read_region0();
        test_write_wait();
        test_both_strobes();
        test_unmapped();
        test_overlap();
        test_overrun();
        test_random();
        test_saturation();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
